count_avg_collector: RTL and testbench
======================================

# count_avg_collector

Downstream consumer of the count FSM. It detects each measurement completion (busy falling), captures `count_value`, and accumulates 2^L valid measurements per window. It then publishes the truncated average plus window min/max and miss count through a valid/ready handshake to the ranging back-end.

## Interface
- `L`, default 2: log2 of valid samples per window (1..4).
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `en`  in  1: collection enable; a low level discards any partial window.
- `clear`  in  1: synchronous clear of the window, the result register and `overrun`.
- `busy`  in  1: count FSM busy.
- `count_value`  in  5: count FSM result, valid on the cycle `busy` falls.
- `out_ready`  in  1: consumer accepts the result.
- `out_valid`  out  1: result available.
- `avg_value`  out  5: `floor(sum / 2^L)`.
- `min_value`  out  5: smallest valid sample in the window.
- `max_value`  out  5: largest valid sample in the window.
- `miss_count`  out  4: misses seen during the window, saturating at 15.
- `overrun`  out  1: sticky flag; a completed window was dropped.
- `collecting`  out  1: FSM is in COLLECT.

## Operation
- Completion event `done = busy_q & ~busy`.
  - `busy_q` is a registered copy of `busy`, reset to 0.
- A sample with `count_value == 31` (COUNT_MISS) is a miss.
  - It increments `miss_count` (saturating) only.
  - It does not advance the window.
- A valid sample (0..30):
  - `sum += count_value`; `sum` is 5+L bits and cannot overflow.
  - min and max are updated; the min accumulator initialises to 31, the max accumulator to 0.
  - `nsamp` increments.
- FSM states:
  - IDLE: accumulators cleared. Goes to COLLECT when `en = 1`.
  - COLLECT: captures on `done`.
    - When the 2^L-th valid sample is captured, the window closes and the accumulators reset for the next window; the state stays COLLECT.
    - `en = 0` goes to IDLE and discards the partial window, including its misses.
- Window close:
  - If the result register is free, or is being accepted this cycle (`out_valid & out_ready`), it loads avg/min/max/miss_count and `out_valid = 1`.
  - Otherwise the new result is dropped, `overrun` is set, and the held result stays unchanged.
- Handshake:
  - `out_valid` stays high until `out_ready` is sampled high.
  - The outputs are stable while `out_valid = 1 & out_ready = 0`.
- `clear`:
  - Clears the accumulators, `out_valid`, and `overrun`. Output data registers go to 0.
  - FSM goes to IDLE.
  - Has priority over a same-cycle `done` and window close; that sample is lost.
- `rst`:
  - All outputs 0, FSM IDLE, `busy_q = 0`, accumulators cleared.
  - Applies mid-window or with a result pending; the pending result is lost.
- `done` while in IDLE (including the cycle `en` rises) is ignored.

## Timing
- `busy` falls at edge k, so `done` is seen in cycle k. The sample is captured at edge k+1.
- If that sample completes the window, `out_valid = 1` and the data are valid from edge k+1. Latency is 1 cycle from the busy fall.
- Back-to-back windows:
  - A result accepted in the same cycle the next window closes is replaced seamlessly; `out_valid` stays 1 and there is no overrun.
- `collecting` is registered and rises 1 cycle after `en` rises.
- `overrun` is set at the edge of the dropped close.
- Minimum completion spacing is 2 cycles, imposed by the busy pulse. There are no throughput limits beyond that.

## Structure
- Shared package `count_pkg`:
  - `typedef logic [4:0] count_t`
  - `localparam count_t COUNT_MISS = 5'd31`
  - `typedef enum logic {IDLE, COLLECT} coll_state_t`
- Sub-module `busy_edge_det`: registers `busy` and emits the one-cycle `done` pulse; reset to 0.
- The rest (accumulators, FSM, result register) is flat in `count_avg_collector`.

## Test plan
- Reset and idle:
  - Assert `rst` for 3 cycles while `busy` is toggling.
  - Every output must be 0 and `collecting = 0`.
  - No capture may occur while `en = 0`.
- Basic window, L = 2:
  - `en = 1`; completions with 10, 12, 14, 16.
  - `out_valid` must rise 1 cycle after the 4th busy fall, with avg = 13, min = 10, max = 16, miss_count = 0.
  - `out_ready = 1` must drop `out_valid` on the next edge.
- Misses:
  - Completions 31, 8, 31, 8, 8, 8.
  - Result: avg = 8, min = max = 8, miss_count = 2.
  - The window must close only on the 6th completion.
- Backpressure and overrun:
  - Hold `out_ready = 0`; complete two windows (all 5s, then all 20s).
  - `out_valid` holds avg = 5; `overrun = 1` after the second close.
  - `clear` then gives `out_valid = 0` and `overrun = 0`.
- Enable drop:
  - Capture two samples of 30, drop `en` for 1 cycle, raise it, then capture four samples of 20.
  - Result: avg = 20, max = 20 (the partial window is discarded).
- Simultaneous events:
  - `clear` in the same cycle as the 4th `done`: no result, FSM goes to IDLE.
  - `out_ready` in the same cycle as a window close: the new result is loaded, `out_valid` stays 1, `overrun = 0`.

Source files
------------

// File: rtl/count_pkg.sv
// Shared types for the count FSM and its downstream consumers.
package count_pkg;

    typedef logic [4:0] count_t;

    localparam count_t COUNT_MISS = 5'd31;

    typedef enum logic {IDLE, COLLECT} coll_state_t;

endpackage

// File: rtl/busy_edge_det.sv
// Registers the count FSM busy line and flags its falling edge as a one-cycle done pulse.
module busy_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic busy,
    output logic done
);

    logic busy_q;

    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) busy_q <= 1'b0;
        else     busy_q <= busy;
    end

    assign done = busy_q & ~busy;

endmodule

// File: rtl/count_avg_collector.sv
// Collects 2^L valid count results per window and publishes avg/min/max/misses
// through a valid/ready result register.
module count_avg_collector
    import count_pkg::*;
#(
    parameter int L = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  logic   clear,
    input  logic   busy,
    input  count_t count_value,
    input  logic   out_ready,
    output logic   out_valid,
    output count_t avg_value,
    output count_t min_value,
    output count_t max_value,
    output logic [3:0] miss_count,
    output logic   overrun,
    output logic   collecting
);

    typedef struct packed {
        logic [4+L:0] sum;
        count_t       min;
        count_t       max;
        logic [L-1:0] nsamp;
        logic [3:0]   miss;
    } acc_t;

    localparam acc_t ACC_INIT = '{sum: '0, min: COUNT_MISS, max: '0, nsamp: '0, miss: '0};

    logic        done;
    coll_state_t state;
    acc_t        acc;

    busy_edge_det u_busy_edge_det (
        .clk  (clk),
        .rst  (rst),
        .busy (busy),
        .done (done)
    );

    logic         capture;
    logic         is_miss;
    logic         valid_cap;
    logic         win_close;
    logic         res_free;
    logic [4+L:0] sum_next;
    count_t       min_next;
    count_t       max_next;

    always_comb begin
        capture   = (state == COLLECT) & en & done;
        is_miss   = (count_value == COUNT_MISS);
        valid_cap = capture & ~is_miss;
        win_close = valid_cap & (&acc.nsamp);
        res_free  = ~out_valid | out_ready;
        sum_next  = acc.sum + (5+L)'(count_value);
        min_next  = (count_value < acc.min) ? count_value : acc.min;
        max_next  = (count_value > acc.max) ? count_value : acc.max;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state      <= IDLE;
            collecting <= 1'b0;
            acc        <= ACC_INIT;
            out_valid  <= 1'b0;
            avg_value  <= '0;
            min_value  <= '0;
            max_value  <= '0;
            miss_count <= '0;
            overrun    <= 1'b0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;

            case (state)
                IDLE: begin
                    acc <= ACC_INIT;
                    if (en) begin
                        state      <= COLLECT;
                        collecting <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (!en) begin
                        state      <= IDLE;
                        collecting <= 1'b0;
                        acc        <= ACC_INIT;
                    end else if (win_close) begin
                        acc <= ACC_INIT;
                        // A full register that is not draining this cycle keeps its result.
                        if (res_free) begin
                            out_valid  <= 1'b1;
                            avg_value  <= sum_next[L +: 5];
                            min_value  <= min_next;
                            max_value  <= max_next;
                            miss_count <= acc.miss;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else if (valid_cap) begin
                        acc.sum   <= sum_next;
                        acc.min   <= min_next;
                        acc.max   <= max_next;
                        acc.nsamp <= acc.nsamp + 1'b1;
                    end else if (capture && acc.miss != 4'd15) begin
                        acc.miss <= acc.miss + 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    collecting <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_avg_collector.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized phase compared every cycle against a window-level reference model.
module tb_count_avg_collector;

    localparam int L   = 2;
    localparam int WIN = 1 << L;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       clear = 1'b0;
    logic       busy = 1'b0;
    logic [4:0] count_value = 5'd0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [4:0] avg_value;
    logic [4:0] min_value;
    logic [4:0] max_value;
    logic [3:0] miss_count;
    logic       overrun;
    logic       collecting;

    count_avg_collector #(.L(L)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .clear       (clear),
        .busy        (busy),
        .count_value (count_value),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .avg_value   (avg_value),
        .min_value   (min_value),
        .max_value   (max_value),
        .miss_count  (miss_count),
        .overrun     (overrun),
        .collecting  (collecting)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a window is a list of valid samples; results are derived by plain arithmetic.
    bit m_busy_q = 0;
    bit m_coll = 0;
    bit m_valid = 0;
    bit m_ovr = 0;
    int m_avg = 0, m_min = 0, m_max = 0, m_mcnt = 0;
    int m_miss = 0;
    int win[$];

    task automatic model_step();
        bit done;
        int s, mn, mx;
        done = m_busy_q && !busy;
        if (rst) begin
            m_busy_q = 0;
            m_coll = 0; m_valid = 0; m_ovr = 0;
            m_avg = 0; m_min = 0; m_max = 0; m_mcnt = 0;
            win.delete(); m_miss = 0;
            return;
        end
        m_busy_q = busy;
        if (clear) begin
            m_coll = 0; m_valid = 0; m_ovr = 0;
            m_avg = 0; m_min = 0; m_max = 0; m_mcnt = 0;
            win.delete(); m_miss = 0;
            return;
        end
        if (m_valid && out_ready) m_valid = 0;
        if (!m_coll || !en) begin
            m_coll = en && !m_coll ? 1 : (m_coll && !en ? 0 : m_coll);
            win.delete(); m_miss = 0;
        end else if (done) begin
            if (count_value == 5'd31) begin
                if (m_miss < 15) m_miss++;
            end else begin
                win.push_back(int'(count_value));
                if (win.size() == WIN) begin
                    s = 0; mn = 31; mx = 0;
                    foreach (win[i]) begin
                        s += win[i];
                        if (win[i] < mn) mn = win[i];
                        if (win[i] > mx) mx = win[i];
                    end
                    if (!m_valid) begin
                        m_valid = 1;
                        m_avg = s / WIN; m_min = mn; m_max = mx; m_mcnt = m_miss;
                    end else begin
                        m_ovr = 1;
                    end
                    win.delete(); m_miss = 0;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        check("cycle", {10'd0, out_valid, avg_value, min_value, max_value, miss_count, overrun, collecting},
              {10'd0, m_valid, 5'(m_avg), 5'(m_min), 5'(m_max), 4'(m_mcnt), m_ovr, m_coll});
    end

    task automatic pulse(input logic [4:0] v);
        @(negedge clk) busy = 1'b1; count_value = 5'($urandom);
        @(negedge clk) busy = 1'b0; count_value = v;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic accept();
        @(negedge clk) out_ready = 1'b1;
        @(negedge clk) out_ready = 1'b0;
    endtask

    initial begin
        // Reset with busy toggling, then completions while disabled.
        repeat (3) @(negedge clk) busy = ~busy;
        @(negedge clk) rst = 1'b0; busy = 1'b0;
        settle();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", {12'd0, avg_value, min_value, max_value, miss_count, overrun}, 32'd0);
        check("rst_collecting", 32'(collecting), 32'd0);
        pulse(5'd7); pulse(5'd9);
        settle();
        check("idle_no_capture", 32'(out_valid), 32'd0);

        // Basic window.
        @(negedge clk) en = 1'b1;
        settle();
        check("collecting_rise", 32'(collecting), 32'd1);
        pulse(5'd10); pulse(5'd12); pulse(5'd14); pulse(5'd16);
        #1 check("basic_not_yet", 32'(out_valid), 32'd0);
        settle();
        check("basic_valid", 32'(out_valid), 32'd1);
        check("basic_avg", 32'(avg_value), 32'd13);
        check("basic_min", 32'(min_value), 32'd10);
        check("basic_max", 32'(max_value), 32'd16);
        check("basic_miss", 32'(miss_count), 32'd0);
        @(negedge clk) out_ready = 1'b1;
        settle();
        check("basic_accept", 32'(out_valid), 32'd0);
        @(negedge clk) out_ready = 1'b0;

        // Misses do not advance the window.
        pulse(5'd31); pulse(5'd8); pulse(5'd31); pulse(5'd8); pulse(5'd8);
        settle();
        check("miss_not_closed", 32'(out_valid), 32'd0);
        pulse(5'd8);
        settle();
        check("miss_valid", 32'(out_valid), 32'd1);
        check("miss_avg", 32'(avg_value), 32'd8);
        check("miss_minmax", {min_value, max_value}, {5'd8, 5'd8});
        check("miss_count", 32'(miss_count), 32'd2);
        accept();

        // Backpressure and overrun, then clear.
        repeat (WIN) pulse(5'd5);
        settle();
        check("bp_first", {out_valid, avg_value}, {1'b1, 5'd5});
        repeat (WIN) pulse(5'd20);
        settle();
        check("bp_hold", {out_valid, avg_value}, {1'b1, 5'd5});
        check("bp_overrun", 32'(overrun), 32'd1);
        @(negedge clk) clear = 1'b1;
        settle();
        check("clear_out", {out_valid, overrun, collecting}, 3'b000);
        @(negedge clk) clear = 1'b0;

        // Enable drop discards the partial window.
        pulse(5'd30); pulse(5'd30);
        @(negedge clk) en = 1'b0;
        @(negedge clk) en = 1'b1;
        repeat (WIN) pulse(5'd20);
        settle();
        check("endrop_valid", 32'(out_valid), 32'd1);
        check("endrop_avg_max", {avg_value, max_value}, {5'd20, 5'd20});
        accept();

        // Clear on the closing completion loses the window.
        pulse(5'd1); pulse(5'd2); pulse(5'd3);
        @(negedge clk) busy = 1'b1;
        @(negedge clk) busy = 1'b0; count_value = 5'd4; clear = 1'b1;
        settle();
        check("clear_close", {out_valid, collecting}, 2'b00);
        @(negedge clk) clear = 1'b0;

        // Acceptance in the same cycle as a window close.
        repeat (WIN) pulse(5'd9);
        settle();
        check("pend_first", {out_valid, avg_value}, {1'b1, 5'd9});
        pulse(5'd17); pulse(5'd17); pulse(5'd17);
        @(negedge clk) busy = 1'b1;
        @(negedge clk) busy = 1'b0; count_value = 5'd17; out_ready = 1'b1;
        settle();
        check("seamless", {out_valid, avg_value, overrun}, {1'b1, 5'd17, 1'b0});
        @(negedge clk) out_ready = 1'b0;

        // Randomized phase, checked by the per-cycle model compare.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst         = ($urandom_range(0, 599) == 0);
            clear       = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 39) == 0) en = ~en;
            out_ready   = ($urandom_range(0, 3) == 0);
            busy        = $urandom_range(0, 1) == 1;
            count_value = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 30));
        end
        @(negedge clk) rst = 1'b0; clear = 1'b0;
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
